// File: rtl/sram_march_bist.sv
// March-style BIST for an external async SRAM: write P, verify P, write ~P, verify ~P over all addresses.
// Latency: done rises 2*N*(3+2*WAIT_CYC)+4 cycles after the accepting start; all bus outputs are registered.
// Backpressure: none; start is a single-cycle request that is ignored while busy.
module sram_march_bist #(
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 8,
    parameter int WAIT_CYC = 2,
    parameter int ERR_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        pattern,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [DATA_W-1:0] sram_d_o,
    output logic              sram_d_oe,
    input  logic [DATA_W-1:0] sram_d_i
);

    localparam int                CNT_W     = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WAIT_CYC - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

    typedef enum logic [2:0] {
        IDLE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        RD_ADDR,
        RD_WAIT,
        TURN,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          pass_q, pass_d;
    logic [1:0]          pat_q, pat_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0]   fail_data_q, fail_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ce_n_q, ce_n_d;
    logic                oe_n_q, oe_n_d;
    logic                we_n_q, we_n_d;
    logic                d_oe_q, d_oe_d;
    logic [DATA_W-1:0]   d_o_q, d_o_d;
    logic [DATA_W-1:0]   exp_dat;
    logic [DATA_W-1:0]   wr_dat;

    function automatic logic [DATA_W-1:0] pattern_data(input logic [1:0] pat,
                                                       input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        case (pat)
            2'd0: v = '0;
            2'd1: v = '1;
            2'd2: begin
                // 0xAA on even addresses, 0x55 on odd, replicated across the word
                for (int i = 0; i < DATA_W; i++) begin
                    v[i] = a[0] ^ i[0];
                end
            end
            default: v = DATA_W'(a);
        endcase
        return v;
    endfunction

    // Second half of the march (pass index 2 and 3) works on the inverted pattern.
    assign exp_dat = pattern_data(pat_q, addr_q) ^ {DATA_W{pass_q[1]}};
    assign wr_dat  = pattern_data(pat_d, addr_d) ^ {DATA_W{pass_d[1]}};

    always_comb begin
        state_d     = state_q;
        pass_d      = pass_q;
        pat_d       = pat_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        busy_d      = busy_q;
        done_d      = done_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    pat_d       = pattern;
                    err_d       = '0;
                    fail_addr_d = '0;
                    fail_data_d = '0;
                    done_d      = 1'b0;
                    busy_d      = 1'b1;
                    pass_d      = 2'd0;
                    addr_d      = '0;
                    cnt_d       = '0;
                    state_d     = WR_SETUP;
                end
            end
            WR_SETUP: begin
                cnt_d   = '0;
                state_d = WR_PULSE;
            end
            WR_PULSE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WR_HOLD: begin
                addr_d  = addr_q + 1'b1;
                state_d = (addr_q == ADDR_LAST) ? TURN : WR_SETUP;
            end
            RD_ADDR: begin
                cnt_d   = '0;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    if (sram_d_i != exp_dat) begin
                        // err_q only returns to zero on a new start, so zero marks the first miss
                        if (err_q == '0) begin
                            fail_addr_d = addr_q;
                            fail_data_d = sram_d_i;
                        end
                        if (err_q != ERR_MAX) begin
                            err_d = err_q + 1'b1;
                        end
                    end
                    addr_d  = addr_q + 1'b1;
                    state_d = (addr_q == ADDR_LAST) ? TURN : RD_ADDR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TURN: begin
                if (pass_q == 2'd3) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    pass_d  = pass_q + 2'd1;
                    state_d = pass_q[0] ? WR_SETUP : RD_ADDR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus controls are decoded from the next state so the pins come straight from flops.
    always_comb begin
        ce_n_d = 1'b1;
        oe_n_d = 1'b1;
        we_n_d = 1'b1;
        d_oe_d = 1'b0;
        d_o_d  = d_o_q;
        case (state_d)
            WR_SETUP: begin
                ce_n_d = 1'b0;
                d_oe_d = 1'b1;
                d_o_d  = wr_dat;
            end
            WR_PULSE: begin
                ce_n_d = 1'b0;
                we_n_d = 1'b0;
                d_oe_d = 1'b1;
            end
            WR_HOLD: begin
                ce_n_d = 1'b0;
                d_oe_d = 1'b1;
            end
            RD_ADDR, RD_WAIT: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
            end
            TURN: ce_n_d = 1'b0;
            default: ce_n_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pass_q      <= 2'd0;
            pat_q       <= 2'd0;
            addr_q      <= '0;
            cnt_q       <= '0;
            err_q       <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            d_oe_q      <= 1'b0;
            d_o_q       <= '0;
        end else begin
            state_q     <= state_d;
            pass_q      <= pass_d;
            pat_q       <= pat_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            d_oe_q      <= d_oe_d;
            d_o_q       <= d_o_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = done_q && (err_q == '0);
    assign err_count = err_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
    assign sram_addr = addr_q;
    assign sram_ce_n = ce_n_q;
    assign sram_oe_n = oe_n_q;
    assign sram_we_n = we_n_q;
    assign sram_d_o  = d_o_q;
    assign sram_d_oe = d_oe_q;

endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: several parameterisations, each with an SRAM model,
// fault injection and a bus protocol / write-data monitor.
module tb_sram_march_bist;

    localparam int NI = 5;

    function automatic int aw_of(input int k);
        if (k == 2) return 10;
        if (k >= 3) return 3;
        return 2;
    endfunction

    function automatic int wc_of(input int k);
        if (k == 3) return 3;
        if (k == 4) return 2;
        return 1;
    endfunction

    function automatic int ew_of(input int k);
        return (k == 1) ? 2 : 16;
    endfunction

    function automatic logic [7:0] exp_data(input int pat, input int a);
        case (pat)
            0: return 8'h00;
            1: return 8'hFF;
            2: return (a % 2 == 1) ? 8'h55 : 8'hAA;
            default: return 8'(a % 256);
        endcase
    endfunction

    // j-th write of a whole run: first N writes carry the pattern, next N its inverse
    function automatic logic [7:0] exp_wr(input int pat, input int j, input int n);
        return exp_data(pat, j % n) ^ ((j >= n) ? 8'hFF : 8'h00);
    endfunction

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0] start_a;
    logic [NI-1:0] fall_a;
    logic [NI-1:0] clr_a;
    logic [1:0]    pat_a  [NI];
    logic [7:0]    s1_a   [NI];
    logic [7:0]    s0_a   [NI];
    int            fadr_a [NI];

    logic [NI-1:0] busy_a, done_a, pass_a;
    int            err_a  [NI];
    int            fa_a   [NI];
    logic [7:0]    fd_a   [NI];
    logic [3:0]    bus_a  [NI];
    int            nwr_a  [NI];
    int            wbad_a [NI];
    int            viol_a [NI];

    int checks = 0;
    int failures = 0;

    for (genvar k = 0; k < NI; k++) begin : g
        localparam int AW = aw_of(k);
        localparam int WC = wc_of(k);
        localparam int EW = ew_of(k);
        localparam int N  = 1 << AW;

        logic          busy, done, pass, ce_n, oe_n, we_n, d_oe;
        logic [EW-1:0] err_count;
        logic [AW-1:0] fail_addr, addr, low_addr;
        logic [7:0]    fail_data, d_o, d_i;
        logic [7:0]    mem [N];
        logic          we_prev;
        int            nwr, wbad, viol, low;

        sram_march_bist #(
            .ADDR_W(AW), .DATA_W(8), .WAIT_CYC(WC), .ERR_W(EW)
        ) dut (
            .clk(clk), .rst_n(rst_n), .start(start_a[k]), .pattern(pat_a[k]),
            .busy(busy), .done(done), .pass(pass), .err_count(err_count),
            .fail_addr(fail_addr), .fail_data(fail_data), .sram_addr(addr),
            .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n),
            .sram_d_o(d_o), .sram_d_oe(d_oe), .sram_d_i(d_i)
        );

        // SRAM with optional stuck bits; read data is registered as in the pad
        always @(posedge clk) begin
            if (!we_n) mem[addr] <= d_o;
            if (oe_n) d_i <= 8'h00;
            else if (fall_a[k] || int'(addr) == fadr_a[k]) d_i <= (mem[addr] | s1_a[k]) & ~s0_a[k];
            else d_i <= mem[addr];
        end

        always @(negedge clk) begin
            int v;
            v = 0;
            if (clr_a[k]) begin
                nwr <= 0; wbad <= 0; viol <= 0; low <= 0; we_prev <= 1'b1;
            end else begin
                if (d_oe && !oe_n) v++;
                if (!we_n && !oe_n) v++;
                if (busy && ce_n) v++;
                if (!we_n) begin
                    if (!d_oe) v++;
                    if (low > 0 && addr != low_addr) v++;
                    low_addr <= addr;
                    low <= low + 1;
                end else if (!we_prev) begin
                    if (low != WC) v++;
                    if (int'(addr) != nwr % N || d_o != exp_wr(int'(pat_a[k]), nwr, N)) wbad <= wbad + 1;
                    nwr <= nwr + 1;
                    low <= 0;
                end
                viol <= viol + v;
                we_prev <= we_n;
            end
        end

        assign busy_a[k] = busy;
        assign done_a[k] = done;
        assign pass_a[k] = pass;
        assign err_a[k]  = int'(err_count);
        assign fa_a[k]   = int'(fail_addr);
        assign fd_a[k]   = fail_data;
        assign bus_a[k]  = {ce_n, oe_n, we_n, d_oe};
        assign nwr_a[k]  = nwr;
        assign wbad_a[k] = wbad;
        assign viol_a[k] = viol;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic ref_model(input int k, input int pat, input logic [7:0] s1, input logic [7:0] s0,
                             input logic fall, input int fadr,
                             output int err, output int fa, output logic [7:0] fd);
        int n, mx;
        logic [7:0] e, r;
        n = 1 << aw_of(k);
        mx = (1 << ew_of(k)) - 1;
        err = 0; fa = 0; fd = 8'h00;
        for (int p = 0; p < 2; p++) begin
            for (int a = 0; a < n; a++) begin
                e = exp_data(pat, a) ^ ((p == 1) ? 8'hFF : 8'h00);
                r = (fall || a == fadr) ? ((e | s1) & ~s0) : e;
                if (r != e) begin
                    if (err == 0) begin fa = a; fd = r; end
                    err++;
                end
            end
        end
        if (err > mx) err = mx;
    endtask

    task automatic launch(input int k, input int pat, input logic [7:0] s1, input logic [7:0] s0,
                          input logic fall, input int fadr);
        @(posedge clk); #1;
        pat_a[k] = 2'(pat); s1_a[k] = s1; s0_a[k] = s0; fall_a[k] = fall; fadr_a[k] = fadr;
        clr_a[k] = 1'b1;
        @(negedge clk); #1;
        clr_a[k] = 1'b0;
        start_a[k] = 1'b1;
        @(posedge clk); #1;
        start_a[k] = 1'b0;
    endtask

    task automatic run(input int k, input int pat, input logic [7:0] s1, input logic [7:0] s0,
                       input logic fall, input int fadr, input int e_err, input int e_fa,
                       input logic [7:0] e_fd, input logic e_pass, input bit mid, input string tag);
        int n, s, cyc;
        n = 1 << aw_of(k);
        s = 2 * n * (3 + 2 * wc_of(k)) + 4;
        launch(k, pat, s1, s0, fall, fadr);
        chk({tag, "_busy_on"}, busy_a[k], 1);
        chk({tag, "_done_clr"}, done_a[k], 0);
        cyc = 0;
        while (!done_a[k] && cyc < s + 20) begin
            @(posedge clk); #1;
            cyc++;
            start_a[k] = mid && (cyc == 7);
        end
        start_a[k] = 1'b0;
        chk({tag, "_cycles"}, cyc, s);
        chk({tag, "_busy_off"}, busy_a[k], 0);
        chk({tag, "_err"}, err_a[k], e_err);
        chk({tag, "_fail_addr"}, fa_a[k], e_fa);
        chk({tag, "_fail_data"}, fd_a[k], e_fd);
        chk({tag, "_pass"}, pass_a[k], e_pass);
        chk({tag, "_bus_idle"}, bus_a[k], 4'b1110);
        chk({tag, "_writes"}, nwr_a[k], 2 * n);
        chk({tag, "_wr_data"}, wbad_a[k], 0);
        chk({tag, "_protocol"}, viol_a[k], 0);
    endtask

    typedef struct {
        int         k;
        int         pat;
        logic [7:0] s1;
        logic [7:0] s0;
        logic       fall;
        int         fadr;
        int         err;
        int         fa;
        logic [7:0] fd;
        logic       pass;
        bit         mid;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int e_err, e_fa, k, pat, kind, fadr;
        logic [7:0] e_fd, s1, s0;
        logic fall;

        tbl[0] = '{0, 2, 8'h00, 8'h00, 1'b0, -1, 0,  0, 8'h00, 1'b1, 1'b0};
        tbl[1] = '{0, 0, 8'h01, 8'h00, 1'b0,  2, 1,  2, 8'h01, 1'b0, 1'b0};
        tbl[2] = '{1, 1, 8'h00, 8'hFF, 1'b1, -1, 3,  0, 8'h00, 1'b0, 1'b0};
        tbl[3] = '{0, 3, 8'h00, 8'h00, 1'b0, -1, 0,  0, 8'h00, 1'b1, 1'b1};
        tbl[4] = '{0, 1, 8'h00, 8'h80, 1'b0,  3, 1,  3, 8'h7F, 1'b0, 1'b0};
        tbl[5] = '{2, 3, 8'h00, 8'h00, 1'b0, -1, 0,  0, 8'h00, 1'b1, 1'b0};
        tbl[6] = '{3, 2, 8'h0F, 8'h00, 1'b1, -1, 16, 0, 8'hAF, 1'b0, 1'b0};
        tbl[7] = '{4, 0, 8'h00, 8'h01, 1'b0,  5, 1,  5, 8'hFE, 1'b0, 1'b0};

        start_a = '0;
        fall_a  = '0;
        clr_a   = '1;
        for (int i = 0; i < NI; i++) begin
            pat_a[i] = 2'd0; s1_a[i] = 8'h00; s0_a[i] = 8'h00; fadr_a[i] = -1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("reset_bus_%0d", i), bus_a[i], 4'b1110);
            chk($sformatf("reset_busy_%0d", i), busy_a[i], 0);
            chk($sformatf("reset_done_%0d", i), done_a[i], 0);
        end
        chk("reset_err", err_a[0], 0);
        chk("reset_pass", pass_a[0], 0);
        rst_n = 1'b1;
        clr_a = '0;

        for (int i = 0; i < 8; i++) begin
            run(tbl[i].k, tbl[i].pat, tbl[i].s1, tbl[i].s0, tbl[i].fall, tbl[i].fadr,
                tbl[i].err, tbl[i].fa, tbl[i].fd, tbl[i].pass, tbl[i].mid, $sformatf("vec%0d", i));
        end

        // abort mid read pass with errors already counted
        launch(0, 1, 8'h00, 8'hFF, 1'b1, -1);
        repeat (20) @(posedge clk);
        #1;
        chk("abort_pre_busy", busy_a[0], 1);
        chk("abort_pre_err", (err_a[0] > 0) ? 1 : 0, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy_a[0], 0);
        chk("abort_done", done_a[0], 0);
        chk("abort_err", err_a[0], 0);
        chk("abort_bus", bus_a[0], 4'b1110);
        chk("abort_addr", g[0].addr, 0);
        chk("abort_d_o", g[0].d_o, 0);
        chk("abort_fail", {fa_a[0], 24'(fd_a[0])}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int r = 0; r < 12; r++) begin
            k    = (r % 3 == 0) ? 0 : 3 + (r % 2);
            pat  = int'($urandom_range(0, 3));
            kind = int'($urandom_range(0, 2));
            s1   = 8'($urandom_range(0, 255));
            s0   = 8'($urandom_range(0, 255));
            fall = (kind == 2);
            fadr = (kind == 1) ? int'($urandom_range(0, (1 << aw_of(k)) - 1)) : -1;
            if (kind == 0) begin s1 = 8'h00; s0 = 8'h00; end
            ref_model(k, pat, s1, s0, fall, fadr, e_err, e_fa, e_fd);
            run(k, pat, s1, s0, fall, fadr, e_err, e_fa, e_fd, e_err == 0, 1'b0,
                $sformatf("rnd%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
